mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Block SHALL have no parameters; all widths fixed.
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_req  in  1  fetch-side read request, held until i_done.
REQ-005 i_addr  in  32  fetch-side word address, stable while i_req.
REQ-006 d_req  in  1  data-side request, held until d_done.
REQ-007 d_wen  in  4  data-side byte write enables; 4'b0000 = read.
REQ-008 d_addr / d_wdata  in  32 / 32  data-side address and store data, stable while d_req.
REQ-009 i_done / d_done  out  1 / 1  one-cycle completion pulse per side.
REQ-010 i_rdata / d_rdata  out  32 / 32  registered read data, valid from done cycle and held until that side's next done.
REQ-011 i_stallreq / d_stallreq  out  1 / 1  pipeline stall requests toward the stall controller.
REQ-012 sram_en  out  1 / sram_wen  out  4 / sram_addr  out  32 / sram_wdata  out  32  shared single-port SRAM command.
REQ-013 sram_rdata  in  32  SRAM read data, valid one cycle after sram_en.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, RESP; encoding free.
REQ-015 IDLE: no request -> stay; any request -> latch owner, addr, wen, wdata (i side wen forced 4'b0000), go ACCESS.
REQ-016 ACCESS: drive sram_en=1 and latched wen/addr/wdata for exactly this one cycle; go RESP.
REQ-017 RESP: capture sram_rdata into owner's rdata register on read only (write leaves it unchanged), pulse owner's done, go IDLE.
REQ-018 Outside ACCESS, sram_en and sram_wen SHALL be 0.
REQ-019 Latency: request seen in IDLE at cycle N -> sram_en at N+1 -> done at N+2; next request accepted at N+3 earliest.
REQ-020 x_stallreq SHALL equal x_req & ~x_done (combinational), so pipeline stalls until and releases on done cycle.
REQ-021 Both requests in IDLE same cycle: grant per REQ-028/029; loser keeps stallreq high and is served next IDLE.
REQ-022 Request arriving while busy SHALL not disturb the in-flight access; it waits for IDLE.
REQ-023 Request dropped before grant SHALL be ignored; dropping after grant is illegal and need not be handled.
REQ-024 At most one done pulse per cycle; never both sides.

Reset
REQ-025 rst asserted at any time, including mid-ACCESS or RESP: FSM -> IDLE immediately, in-flight access abandoned with no done pulse.
REQ-026 Reset values: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, i_done=d_done=0, i_rdata=d_rdata=0, last-grant=fetch.

Configuration
REQ-027 Macro MEM_ARB_RR_EN selects arbitration policy.
REQ-028 Without MEM_ARB_RR_EN: fixed priority, data side always wins simultaneous requests.
REQ-029 With MEM_ARB_RR_EN: round-robin; simultaneous requests granted to side opposite last-grant register, updated on every grant; after reset data wins first.

Verification
REQ-030 Single fetch: i_req=1, i_addr=0x1000, sram_rdata=0xDEADBEEF at RESP -> sram_en at cycle 1, i_done and i_rdata=0xDEADBEEF at cycle 2, i_stallreq high cycles 0-1.
REQ-031 Store: d_req=1, d_wen=4'b0011, d_addr=0x20, d_wdata=0x12345678 -> one ACCESS cycle with sram_wen=4'b0011, d_done at cycle 2, d_rdata unchanged.
REQ-032 Simultaneous i_req and d_req held, no macro -> data served first (d_done cycle 2), fetch next (i_done cycle 5); three back-to-back pairs -> same order each time.
REQ-033 Same as REQ-032 with MEM_ARB_RR_EN -> grants alternate data, fetch, data, fetch...
REQ-034 rst pulsed during ACCESS of a read -> no done pulse, all outputs at reset values, new request after reset completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch-side, data-side and shared SRAM signals
// of the memory arbiter.
//
// Modports:
//   master - requester/SRAM side: drives i_req, i_addr, d_req, d_wen, d_addr,
//            d_wdata and sram_rdata. Observes done pulses, read data, stall
//            requests and the SRAM command.
//   slave  - arbiter side: the mirror image of master.
//
// Signal summary:
//   i_req/i_addr                 fetch read request and word address
//   d_req/d_wen/d_addr/d_wdata   data request, byte enables (0 = read), addr, store data
//   i_done/d_done                one-cycle completion pulses
//   i_rdata/d_rdata              read data per side
//   i_stallreq/d_stallreq        stall requests toward the stall controller
//   sram_en/wen/addr/wdata       single-port SRAM command
//   sram_rdata                   SRAM read data, one cycle after sram_en
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        i_done;
    logic        d_done;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        i_stallreq;
    logic        d_stallreq;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, sram_rdata,
        input  i_done, d_done, i_rdata, d_rdata, i_stallreq, d_stallreq,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, sram_rdata,
        output i_done, d_done, i_rdata, d_rdata, i_stallreq, d_stallreq,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one single-port
// SRAM. Each access takes IDLE -> ACCESS (SRAM command) -> RESP (done pulse).
//
// Ports:
//   clk  - single clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: request/response and SRAM signals
//
// Configuration:
//   MEM_ARB_RR_EN - when defined, simultaneous requests are granted
//                   round-robin (opposite of the last grant, data first after
//                   reset). Default: fixed priority, data side always wins.
module mem_arbiter (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    // Latched command of the access in flight; r_owner: 1 = data side.
    logic        r_owner;
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_valid;
    logic        w_grant_data;
    logic        w_accept;
    logic        w_access;
    logic        w_resp;
    logic        w_resp_read;
    logic        w_i_done;
    logic        w_d_done;

`ifdef MEM_ARB_RR_EN
    // 1 = data side was granted last; resets to fetch so data wins first.
    logic        r_last_grant;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_valid = bus.i_req | bus.d_req;
`ifdef MEM_ARB_RR_EN
        if (bus.i_req && bus.d_req) begin
            w_grant_data = ~r_last_grant;
        end else begin
            w_grant_data = bus.d_req;
        end
`else
        w_grant_data = bus.d_req;
`endif
    end

    assign w_accept = (r_state == ST_IDLE) && w_grant_valid;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant_valid) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Command latch: captured once at grant, stable through ACCESS/RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_wen   <= 4'b0000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_owner <= w_grant_data;
            if (w_grant_data) begin
                r_wen   <= bus.d_wen;
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_wdata;
            end else begin
                // Fetch is always a read.
                r_wen   <= 4'b0000;
                r_addr  <= bus.i_addr;
                r_wdata <= 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    assign w_access    = (r_state == ST_ACCESS);
    assign w_resp      = (r_state == ST_RESP);
    assign w_i_done    = w_resp & ~r_owner;
    assign w_d_done    = w_resp &  r_owner;
    assign w_resp_read = w_resp & (r_wen == 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_rdata <= 32'h0;
            r_d_rdata <= 32'h0;
        end else if (w_resp_read) begin
            if (r_owner) begin
                r_d_rdata <= bus.sram_rdata;
            end else begin
                r_i_rdata <= bus.sram_rdata;
            end
        end
    end

    // SRAM data only arrives in RESP, so during the done cycle the read data is
    // forwarded straight through; afterwards the captured register holds it.
    always_comb begin
        bus.i_rdata = r_i_rdata;
        bus.d_rdata = r_d_rdata;
        if (w_resp_read && !r_owner) begin
            bus.i_rdata = bus.sram_rdata;
        end
        if (w_resp_read && r_owner) begin
            bus.d_rdata = bus.sram_rdata;
        end
    end

    assign bus.i_done     = w_i_done;
    assign bus.d_done     = w_d_done;
    assign bus.i_stallreq = bus.i_req & ~w_i_done;
    assign bus.d_stallreq = bus.d_req & ~w_d_done;

    // ------------------------------------------------------------------
    // SRAM command: enable and byte enables only during ACCESS
    // ------------------------------------------------------------------
    assign bus.sram_en    = w_access;
    assign bus.sram_wen   = w_access ? r_wen : 4'b0000;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table for mem_arbiter plus hand-written
// sequences for back-to-back arbitration and policy-dependent grant order.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] srdata;
        logic [4:0]  flags;  // {i_done, d_done, i_stallreq, d_stallreq, sram_en}
        logic [3:0]  swen;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } vec_t;

    localparam int NumVec = 25;
    vec_t tv [NumVec];

    function automatic vec_t mk(
        input logic rs, input logic ir, input logic [31:0] ia, input logic dr,
        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
        input logic [31:0] sr, input logic [4:0] fl, input logic [3:0] sw,
        input logic [31:0] sa, input logic [31:0] sd, input logic [31:0] eir,
        input logic [31:0] edr);
        vec_t v;
        v.rst = rs; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwen = dw;
        v.daddr = da; v.dwdata = dd; v.srdata = sr; v.flags = fl; v.swen = sw;
        v.saddr = sa; v.swdata = sd; v.irdata = eir; v.drdata = edr;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [136:0] observed();
        return {bus.i_done, bus.d_done, bus.i_stallreq, bus.d_stallreq, bus.sram_en,
                bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.i_rdata, bus.d_rdata};
    endfunction

    initial begin
        int d_cyc;
        int d2_cyc;
        int i_cyc;
        logic both;

        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_wen = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.sram_rdata = 0;

        // Single fetch
        tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    5'b00000, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 32'h1000, 0, 0, 0, 0, 0,
                    5'b00100, 0, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 32'h1000, 0, 0, 0, 0, 0,
                    5'b00101, 0, 32'h1000, 0, 0, 0);
        tv[3]  = mk(0, 1, 32'h1000, 0, 0, 0, 0, 32'hDEADBEEF,
                    5'b10000, 0, 32'h1000, 0, 32'hDEADBEEF, 0);
        tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h55555555,
                    5'b00000, 0, 32'h1000, 0, 32'hDEADBEEF, 0);
        // Store
        tv[5]  = mk(0, 0, 0, 1, 4'b0011, 32'h20, 32'h12345678, 0,
                    5'b00010, 0, 32'h1000, 0, 32'hDEADBEEF, 0);
        tv[6]  = mk(0, 0, 0, 1, 4'b0011, 32'h20, 32'h12345678, 0,
                    5'b00011, 4'b0011, 32'h20, 32'h12345678, 32'hDEADBEEF, 0);
        tv[7]  = mk(0, 0, 0, 1, 4'b0011, 32'h20, 32'h12345678, 32'hCAFEF00D,
                    5'b01000, 0, 32'h20, 32'h12345678, 32'hDEADBEEF, 0);
        tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    5'b00000, 0, 32'h20, 32'h12345678, 32'hDEADBEEF, 0);
        // Simultaneous requests: data read first, fetch waits
        tv[9]  = mk(0, 1, 32'h40, 1, 0, 32'h80, 32'hAAAA, 0,
                    5'b00110, 0, 32'h20, 32'h12345678, 32'hDEADBEEF, 0);
        tv[10] = mk(0, 1, 32'h40, 1, 0, 32'h80, 32'hAAAA, 0,
                    5'b00111, 0, 32'h80, 32'hAAAA, 32'hDEADBEEF, 0);
        tv[11] = mk(0, 1, 32'h40, 1, 0, 32'h80, 32'hAAAA, 32'h11112222,
                    5'b01100, 0, 32'h80, 32'hAAAA, 32'hDEADBEEF, 32'h11112222);
        tv[12] = mk(0, 1, 32'h40, 0, 0, 0, 0, 0,
                    5'b00100, 0, 32'h80, 32'hAAAA, 32'hDEADBEEF, 32'h11112222);
        // Data request arrives while busy and drops before grant: ignored
        tv[13] = mk(0, 1, 32'h40, 1, 4'hF, 32'hC0, 32'h99, 0,
                    5'b00111, 0, 32'h40, 0, 32'hDEADBEEF, 32'h11112222);
        tv[14] = mk(0, 1, 32'h40, 0, 0, 0, 0, 32'h33334444,
                    5'b10000, 0, 32'h40, 0, 32'h33334444, 32'h11112222);
        tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    5'b00000, 0, 32'h40, 0, 32'h33334444, 32'h11112222);
        tv[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    5'b00000, 0, 32'h40, 0, 32'h33334444, 32'h11112222);
        // Reset during ACCESS of a read, then a normal read
        tv[17] = mk(0, 1, 32'h500, 0, 0, 0, 0, 0,
                    5'b00100, 0, 32'h40, 0, 32'h33334444, 32'h11112222);
        tv[18] = mk(0, 1, 32'h500, 0, 0, 0, 0, 0,
                    5'b00101, 0, 32'h500, 0, 32'h33334444, 32'h11112222);
        tv[19] = mk(1, 1, 32'h500, 0, 0, 0, 0, 32'hBAD0BAD0,
                    5'b00100, 0, 0, 0, 0, 0);
        tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 32'hBAD0BAD0,
                    5'b00000, 0, 0, 0, 0, 0);
        tv[21] = mk(0, 1, 32'h600, 0, 0, 0, 0, 0,
                    5'b00100, 0, 0, 0, 0, 0);
        tv[22] = mk(0, 1, 32'h600, 0, 0, 0, 0, 0,
                    5'b00101, 0, 32'h600, 0, 0, 0);
        tv[23] = mk(0, 1, 32'h600, 0, 0, 0, 0, 32'h77778888,
                    5'b10000, 0, 32'h600, 0, 32'h77778888, 0);
        tv[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                    5'b00000, 0, 32'h600, 0, 32'h77778888, 0);

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), 137'h0);
        rst = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            rst            = tv[i].rst;
            bus.i_req      = tv[i].ireq;
            bus.i_addr     = tv[i].iaddr;
            bus.d_req      = tv[i].dreq;
            bus.d_wen      = tv[i].dwen;
            bus.d_addr     = tv[i].daddr;
            bus.d_wdata    = tv[i].dwdata;
            bus.sram_rdata = tv[i].srdata;
            #1;
            check($sformatf("vec%0d", i), observed(),
                  {tv[i].flags, tv[i].swen, tv[i].saddr, tv[i].swdata,
                   tv[i].irdata, tv[i].drdata});
            tick();
        end

        // Three back-to-back simultaneous pairs: data at cycle 2, fetch at 5
        for (int p = 0; p < 3; p++) begin
            d_cyc = -1; i_cyc = -1; both = 1'b0;
            bus.i_req = 1; bus.i_addr = 32'h100 + p; bus.d_req = 1; bus.d_wen = 0;
            bus.d_addr = 32'h200 + p; bus.d_wdata = 0; bus.sram_rdata = 32'hA0 + p;
            for (int c = 0; c < 12 && (d_cyc < 0 || i_cyc < 0); c++) begin
                #1;
                if (bus.i_done && bus.d_done) both = 1'b1;
                if (bus.d_done && d_cyc < 0) begin
                    d_cyc = c; bus.d_req = 0;
                end
                if (bus.i_done && i_cyc < 0) begin
                    i_cyc = c; bus.i_req = 0;
                end
                tick();
            end
            bus.i_req = 0; bus.d_req = 0;
            check($sformatf("pair%0d_d_done_cycle", p), d_cyc, 2);
            check($sformatf("pair%0d_i_done_cycle", p), i_cyc, 5);
            check($sformatf("pair%0d_single_done", p), both, 1'b0);
        end

        // Fetch held, data re-requests right after its first done: the second
        // simultaneous decision exposes the arbitration policy.
        d_cyc = -1; d2_cyc = -1; i_cyc = -1;
        bus.i_req = 1; bus.i_addr = 32'h300; bus.d_req = 1; bus.d_wen = 0;
        bus.d_addr = 32'h400; bus.sram_rdata = 32'h5;
        for (int c = 0; c < 16 && (d2_cyc < 0 || i_cyc < 0); c++) begin
            #1;
            if (bus.d_done) begin
                if (d_cyc < 0) begin
                    d_cyc = c;
                end else if (d2_cyc < 0) begin
                    d2_cyc = c; bus.d_req = 0;
                end
            end
            if (bus.i_done && i_cyc < 0) begin
                i_cyc = c; bus.i_req = 0;
            end
            tick();
        end
        bus.i_req = 0; bus.d_req = 0;
        check("policy_first_d_done", d_cyc, 2);
`ifdef MEM_ARB_RR_EN
        check("policy_i_done", i_cyc, 5);
        check("policy_second_d_done", d2_cyc, 8);
`else
        check("policy_second_d_done", d2_cyc, 5);
        check("policy_i_done", i_cyc, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
